// File: rtl/seg_scan_pkg.sv
// Purpose: shared helpers and constants for the 7-segment digit scanner.
// Latency: n/a (functions and constants only).
// Backpressure: n/a.
package seg_scan_pkg;

    localparam bit SEL_ACTIVE_LOW  = 1'b1;
    localparam bit SEL_ACTIVE_HIGH = 1'b0;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // First index after cur with its mask bit set, searching circularly.
    // Bits above the real digit count are zero, so a mod-16 search gives the
    // same answer as a mod-N search. With no bit set, cur is returned.
    function automatic logic [3:0] next_unmasked(input logic [3:0] cur,
                                                 input logic [15:0] mask);
        logic [3:0] res;
        logic [3:0] cand;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            cand = 4'(int'(cur) + i);
            if (!found && mask[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Purpose: control/status bundle between a scan controller user and the scanner.
// Latency: n/a (wires only).
// Backpressure: none; the scanner free-runs while en is high.
interface seg_scan_decoder_if
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS = 8
) ();
    localparam int IDX_W = idx_w(N_DIGITS);

    logic                en;
    logic [N_DIGITS-1:0] digit_mask;
    logic [N_DIGITS-1:0] dout;
    logic [IDX_W-1:0]    sel;
    logic                tick;
    logic                frame_done;

    modport master (
        output en, digit_mask,
        input  dout, sel, tick, frame_done
    );

    modport slave (
        input  en, digit_mask,
        output dout, sel, tick, frame_done
    );
endinterface

// File: rtl/seg_scan_decoder_onecold.sv
// Purpose: index-plus-valid to one-cold (or one-hot) select decode.
// Latency: combinational.
// Backpressure: none.
module onecold_decoder
    import seg_scan_pkg::*;
#(
    parameter int N          = 4,
    parameter bit ACTIVE_LOW = SEL_ACTIVE_LOW,
    localparam int IDX_W     = idx_w(N)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             vld,
    output logic [N-1:0]     code
);
    // Only the addressed bit may flip to the active level, and only when vld.
    always_comb begin
        code = {N{ACTIVE_LOW}};
        for (int k = 0; k < N; k++) begin
            code[k] = ACTIVE_LOW ^ (vld && (idx == IDX_W'(k)));
        end
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// Purpose: time-multiplexed digit-select driver with blanking, masking and slot/frame strobes.
// Latency: all outputs registered; dout/sel/tick follow the internal counter on the same edge.
// Backpressure: none; en=0 freezes the scan and darkens every digit.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1,
    parameter int SKIP_MASKED  = 0,
    parameter bit ACTIVE_LOW   = SEL_ACTIVE_LOW
) (
    input  logic                clk,
    input  logic                rst,
    seg_scan_decoder_if.slave   bus
);
    localparam int IDX_W = idx_w(N_DIGITS);
    localparam int CNT_W = idx_w(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] SEL_LAST  = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [IDX_W-1:0]    sel_q, sel_n, sel_adv;
    logic                tick_q, tick_n;
    logic                fd_q, fd_n;
    logic                lit_n;
    logic [N_DIGITS-1:0] dout_q, dout_n;

    // Slot index to use after the current slot ends.
    always_comb begin
        sel_adv = sel_q;
        if (SKIP_MASKED != 0) begin
            sel_adv = IDX_W'(next_unmasked(4'(sel_q), 16'(bus.digit_mask)));
        end else begin
            sel_adv = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end
    end

    // Prescaler and slot advance; frame_done is suppressed when nothing is lit
    // in skip mode because sel then just parks.
    always_comb begin
        cnt_n  = cnt_q;
        sel_n  = sel_q;
        tick_n = 1'b0;
        fd_n   = 1'b0;
        if (bus.en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_n  = '0;
                sel_n  = sel_adv;
                tick_n = 1'b1;
                fd_n   = (sel_adv <= sel_q) &&
                         !((SKIP_MASKED != 0) && (bus.digit_mask == '0));
            end else begin
                cnt_n = cnt_q + 1'b1;
            end
        end
    end

    // A digit lights only outside the anti-ghost window and when unmasked.
    always_comb begin
        lit_n = bus.en && (cnt_n >= CNT_BLANK) && bus.digit_mask[sel_n];
    end

    onecold_decoder #(
        .N          (N_DIGITS),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .idx  (sel_n),
        .vld  (lit_n),
        .code (dout_n)
    );

    // Register every output together with the scan state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sel_q  <= '0;
            tick_q <= 1'b0;
            fd_q   <= 1'b0;
            dout_q <= {N_DIGITS{ACTIVE_LOW}};
        end else begin
            cnt_q  <= cnt_n;
            sel_q  <= sel_n;
            tick_q <= tick_n;
            fd_q   <= fd_n;
            dout_q <= dout_n;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.sel        = sel_q;
    assign bus.tick       = tick_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Purpose: directed table-driven check of seg_scan_decoder in plain and skip modes.
// Latency: compares registered outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_seg_scan_decoder;
    import seg_scan_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    seg_scan_decoder_if #(.N_DIGITS(4)) bus_a ();
    seg_scan_decoder_if #(.N_DIGITS(4)) bus_b ();

    seg_scan_decoder #(
        .N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .SKIP_MASKED(0), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a.slave)
    );

    seg_scan_decoder #(
        .N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .SKIP_MASKED(1), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b.slave)
    );

    typedef struct {
        bit         unit;
        bit         rst;
        bit         en;
        logic [3:0] mask;
        logic [3:0] dout;
        logic [1:0] sel;
        bit         tick;
        bit         fd;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input int reps, input bit unit, input bit r, input bit e,
                       input logic [3:0] m, input logic [3:0] d, input logic [1:0] s,
                       input bit t, input bit f);
        vec_t v;
        v = '{unit, r, e, m, d, s, t, f};
        repeat (reps) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Advance one edge on unit A and note tick/frame_done.
    task automatic step_a(output bit t, output bit f);
        @(posedge clk);
        #1;
        t = bus_a.tick;
        f = bus_a.frame_done;
    endtask

    logic [7:0] act, exp;
    int cycles, ticks, fds;
    bit t, f, seen;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.en = 1'b0; bus_a.digit_mask = 4'h0;
        bus_b.en = 1'b0; bus_b.digit_mask = 4'h0;

        // ---- unit A, sequential mode ----
        add(3, 0, 1, 1, 4'b1111, 4'b1111, 0, 0, 0);  // reset held
        add(3, 0, 0, 1, 4'b1111, 4'b1110, 0, 0, 0);
        add(1, 0, 0, 1, 4'b1111, 4'b1111, 1, 1, 0);
        add(3, 0, 0, 1, 4'b1111, 4'b1101, 1, 0, 0);
        add(1, 0, 0, 1, 4'b1111, 4'b1111, 2, 1, 0);
        add(3, 0, 0, 1, 4'b1111, 4'b1011, 2, 0, 0);
        add(1, 0, 0, 1, 4'b1111, 4'b1111, 3, 1, 0);
        add(3, 0, 0, 1, 4'b1111, 4'b0111, 3, 0, 0);
        add(1, 0, 0, 1, 4'b1111, 4'b1111, 0, 1, 1);  // wrap 3->0
        add(3, 0, 0, 1, 4'b1111, 4'b1110, 0, 0, 0);
        // mask 1010: slots 0/2 dark, slot length unchanged
        add(1, 0, 0, 1, 4'b1010, 4'b1111, 1, 1, 0);
        add(3, 0, 0, 1, 4'b1010, 4'b1101, 1, 0, 0);
        add(1, 0, 0, 1, 4'b1010, 4'b1111, 2, 1, 0);
        add(3, 0, 0, 1, 4'b1010, 4'b1111, 2, 0, 0);
        add(1, 0, 0, 1, 4'b1010, 4'b1111, 3, 1, 0);
        add(3, 0, 0, 1, 4'b1010, 4'b0111, 3, 0, 0);
        add(1, 0, 0, 1, 4'b1010, 4'b1111, 0, 1, 1);
        add(3, 0, 0, 1, 4'b1010, 4'b1111, 0, 0, 0);
        // pause at cnt=2 of sel=2
        add(1, 0, 0, 1, 4'b1111, 4'b1111, 1, 1, 0);
        add(3, 0, 0, 1, 4'b1111, 4'b1101, 1, 0, 0);
        add(1, 0, 0, 1, 4'b1111, 4'b1111, 2, 1, 0);
        add(2, 0, 0, 1, 4'b1111, 4'b1011, 2, 0, 0);
        add(5, 0, 0, 0, 4'b1111, 4'b1111, 2, 0, 0);
        add(1, 0, 0, 1, 4'b1111, 4'b1011, 2, 0, 0);
        add(1, 0, 0, 1, 4'b1111, 4'b1111, 3, 1, 0);
        add(2, 0, 0, 1, 4'b1111, 4'b0111, 3, 0, 0);
        // mid-slot reset at sel=3 cnt=2
        add(1, 0, 1, 1, 4'b1111, 4'b1111, 0, 0, 0);
        add(1, 0, 0, 1, 4'b1111, 4'b1110, 0, 0, 0);

        // ---- unit B, skip mode ----
        add(2, 1, 1, 1, 4'b0101, 4'b1111, 0, 0, 0);
        add(3, 1, 0, 1, 4'b0101, 4'b1110, 0, 0, 0);
        add(1, 1, 0, 1, 4'b0101, 4'b1111, 2, 1, 0);
        add(3, 1, 0, 1, 4'b0101, 4'b1011, 2, 0, 0);
        add(1, 1, 0, 1, 4'b0101, 4'b1111, 0, 1, 1);
        add(3, 1, 0, 1, 4'b0101, 4'b1110, 0, 0, 0);
        add(1, 1, 0, 1, 4'b0101, 4'b1111, 2, 1, 0);
        add(3, 1, 0, 1, 4'b0101, 4'b1011, 2, 0, 0);
        add(1, 1, 0, 1, 4'b0101, 4'b1111, 0, 1, 1);
        // nothing lit: sel parks, tick keeps its period, no frame_done
        add(3, 1, 0, 1, 4'b0000, 4'b1111, 0, 0, 0);
        add(1, 1, 0, 1, 4'b0000, 4'b1111, 0, 1, 0);
        add(3, 1, 0, 1, 4'b0000, 4'b1111, 0, 0, 0);
        add(1, 1, 0, 1, 4'b0000, 4'b1111, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (vecs[i].unit == 1'b0) begin
                rst_a = vecs[i].rst; bus_a.en = vecs[i].en; bus_a.digit_mask = vecs[i].mask;
                rst_b = 1'b1;
            end else begin
                rst_b = vecs[i].rst; bus_b.en = vecs[i].en; bus_b.digit_mask = vecs[i].mask;
                rst_a = 1'b1;
            end
            @(posedge clk);
            #1;
            if (vecs[i].unit == 1'b0)
                act = {bus_a.dout, bus_a.sel, bus_a.tick, bus_a.frame_done};
            else
                act = {bus_b.dout, bus_b.sel, bus_b.tick, bus_b.frame_done};
            exp = {vecs[i].dout, vecs[i].sel, vecs[i].tick, vecs[i].fd};
            check("vec {dout,sel,tick,fd}", i, int'(act), int'(exp));
            check("onecold", i, ($countones(~act[7:4]) <= 1) ? 1 : 0, 1);
        end

        // ---- frame_done period on unit A, bounded waits ----
        @(negedge clk);
        rst_b = 1'b1;
        rst_a = 1'b1; bus_a.en = 1'b1; bus_a.digit_mask = 4'b1111;
        @(negedge clk);
        rst_a = 1'b0;
        cycles = 0; seen = 1'b0;
        while (!seen && cycles < 40) begin
            step_a(t, f);
            cycles++;
            if (f) seen = 1'b1;
        end
        check("first frame_done cycle", 0, seen ? cycles : -1, 16);
        cycles = 0; seen = 1'b0; ticks = 0;
        while (!seen && cycles < 40) begin
            step_a(t, f);
            cycles++;
            if (t) ticks++;
            if (f) seen = 1'b1;
        end
        check("frame_done period", 0, seen ? cycles : -1, 16);
        check("ticks per frame", 0, ticks, 4);

        // ---- unit B with empty mask: ticks without frame_done ----
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1; bus_b.en = 1'b1; bus_b.digit_mask = 4'b0000;
        @(negedge clk);
        rst_b = 1'b0;
        ticks = 0; fds = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus_b.tick) ticks++;
            if (bus_b.frame_done) fds++;
        end
        check("empty-mask ticks", 0, ticks, 5);
        check("empty-mask frame_done", 0, fds, 0);
        check("empty-mask sel", 0, int'(bus_b.sel), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
